// File: rtl/lfsr_pkg.sv
// Shared types and the next-state function for the configurable LFSR generator.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  localparam int LFSR_MAX_W = 32;

  // Operates on a zero-extended state; bits at and above 'width' are forced to zero.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] poly,
    input lfsr_mode_e            mode,
    input int                    width
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic [LFSR_MAX_W-1:0] s;
    logic [LFSR_MAX_W-1:0] p;
    logic [LFSR_MAX_W-1:0] nxt;
    logic                  fb;
    if (width >= LFSR_MAX_W) begin
      mask = '1;
    end else begin
      mask = (LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1);
    end
    s = state & mask;
    p = poly & mask;
    if (mode == LFSR_FIB) begin
      fb  = ^(s & p);
      nxt = (s >> 1) | (LFSR_MAX_W'(fb) << (width - 1));
    end else begin
      nxt = (s >> 1) ^ (s[0] ? p : '0);
    end
    return nxt & mask;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Purely combinational one-step advance of the LFSR state.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = 5'b00101,
  parameter lfsr_mode_e       MODE  = LFSR_FIB
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  assign o_next = WIDTH'(lfsr_step(LFSR_MAX_W'(i_state), LFSR_MAX_W'(POLY), MODE, WIDTH));

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator with seed load, zero-seed rejection, wrap detection and period measurement.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = 5'b00101,
  parameter lfsr_mode_e       MODE  = LFSR_FIB,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] lfsr,
  output logic             bit_out,
  output logic             wrap,
  output logic [CNT_W-1:0] period,
  output logic             lockup
);

  generate
    if (SEED == '0 || POLY == '0 || WIDTH < 3 || WIDTH > LFSR_MAX_W) begin : g_param_bad
      $error("lfsr_gen: illegal parameters (SEED and POLY must be non-zero, WIDTH in 3..32)");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_ref_seed;
  logic [CNT_W-1:0] r_step_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_wrap;
  logic             r_lockup;

  logic [WIDTH-1:0] w_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_hits_ref;
  logic             w_seed_zero;

  lfsr_next #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .MODE  (MODE)
  ) u_next (
    .i_state (r_lfsr),
    .o_next  (w_next)
  );

  // Saturating increment shared by the step counter and the period capture.
  assign w_cnt_inc   = (r_step_cnt == CNT_MAX) ? r_step_cnt : r_step_cnt + CNT_W'(1);
  assign w_hits_ref  = (w_next == r_ref_seed);
  assign w_seed_zero = (seed_in == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr     <= SEED;
      r_ref_seed <= SEED;
      r_step_cnt <= '0;
      r_period   <= '0;
      r_wrap     <= 1'b0;
      r_lockup   <= 1'b0;
    end else begin
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
      if (load) begin
        // A zero seed would lock the register up; substitute SEED instead.
        if (w_seed_zero) begin
          r_lfsr     <= SEED;
          r_ref_seed <= SEED;
          r_lockup   <= 1'b1;
        end else begin
          r_lfsr     <= seed_in;
          r_ref_seed <= seed_in;
        end
        r_step_cnt <= '0;
      end else if (en) begin
        r_lfsr <= w_next;
        if (w_hits_ref) begin
          r_wrap     <= 1'b1;
          r_period   <= w_cnt_inc;
          r_step_cnt <= '0;
        end else begin
          r_step_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign lfsr    = r_lfsr;
  assign bit_out = r_lfsr[0];
  assign wrap    = r_wrap;
  assign period  = r_period;
  assign lockup  = r_lockup;

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 5: state width in bits, legal range 3..32.
REQ-002 Parameter POLY, default 5'b00101 (WIDTH bits): tap mask.
REQ-003 Parameter MODE, default LFSR_FIB: structure select, LFSR_FIB or LFSR_GAL.
REQ-004 Parameter SEED, default 1: reset and lockup-recovery state; must be non-zero.
REQ-005 Parameter CNT_W, default 32: width of the step counter and the period register.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 en  in  1  advance the register one step this cycle.
REQ-009 load  in  1  load seed_in this cycle.
REQ-010 seed_in  in  WIDTH  seed value for load.
REQ-011 lfsr  out  WIDTH  current state, registered.
REQ-012 bit_out  out  1  lfsr[0], combinational from state.
REQ-013 wrap  out  1  one-cycle pulse: the state has just returned to the reference seed.
REQ-014 period  out  CNT_W  step count of the last completed cycle, registered.
REQ-015 lockup  out  1  one-cycle pulse: an all-zero seed was rejected.

Function
REQ-016 Fibonacci step (MODE=LFSR_FIB) SHALL be: fb = XOR-reduce(lfsr & POLY); next = {fb, lfsr[WIDTH-1:1]}.
REQ-017 Galois step (MODE=LFSR_GAL) SHALL be: next = (lfsr >> 1) XOR ({WIDTH{lfsr[0]}} & POLY).
REQ-018 Priority SHALL be: reset > load > en > hold.
REQ-019 On load with seed_in != 0:
- lfsr and ref_seed SHALL take seed_in next cycle.
- step_cnt SHALL clear.
- period SHALL be unchanged.
REQ-020 On load with seed_in == 0:
- lfsr and ref_seed SHALL take SEED.
- lockup SHALL pulse high for exactly the next cycle.
REQ-021 With en=1 and load=0, lfsr SHALL advance exactly one step per cycle; with en=0, all state SHALL hold.
REQ-022 Step counting SHALL work as follows:
- step_cnt SHALL increment by 1 per step.
- step_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-023 When a step produces next == ref_seed:
- wrap SHALL be high in the following cycle, coinciding with lfsr == ref_seed.
- period SHALL take step_cnt+1, saturated.
- step_cnt SHALL clear.
REQ-024 wrap and lockup SHALL be low in every cycle other than those in REQ-020/REQ-023.
REQ-025 A load in the same cycle as a would-be wrap step SHALL suppress the wrap; load wins.
REQ-026 lfsr SHALL never hold zero; no reachable input sequence produces the all-zero state.
REQ-027 Output latency: lfsr, period, wrap and lockup SHALL update one cycle after the controlling input edge; bit_out has zero added latency.

Reset
REQ-028 On reset=1 at a rising clk edge, the following SHALL apply next cycle:
- lfsr = SEED
- ref_seed = SEED
- step_cnt = 0
- period = 0
- wrap = 0
- lockup = 0
REQ-029 Reset asserted during a load or step SHALL override that operation completely.
REQ-030 No initial-block initialisation SHALL be relied upon; reset alone defines the state.

Structure
REQ-031 Package lfsr_pkg SHALL hold:
- the mode enum (LFSR_FIB, LFSR_GAL)
- the maximum-width constant, 32
- a function returning the next state for given state, POLY, MODE and WIDTH
REQ-032 Sub-module lfsr_next SHALL wrap that function as a purely combinational next-state block; lfsr_gen holds all registers, counters and control.
REQ-033 Elaboration SHALL fail when SEED == 0, POLY == 0, or WIDTH is outside 3..32.

Verification
REQ-034 WIDTH=5, POLY=00101, FIB, reset, then en=1:
- lfsr SHALL step 00001 -> 10000 -> 01000 -> 00100 -> 10010.
- The first wrap SHALL follow after 31 steps, with period = 31.
REQ-035 WIDTH=4, POLY=1100, GAL, reset, then en=1:
- First step SHALL give 0001 -> 1100.
- wrap SHALL occur after 15 steps, with period = 15.
- All 15 non-zero states SHALL appear once each.
REQ-036 load=1 with seed_in=0:
- lfsr SHALL become SEED next cycle.
- lockup SHALL be high exactly 1 cycle.
- wrap SHALL stay low.
REQ-037 load seed_in=10110 mid-run, then run 31 steps: wrap SHALL pulse when lfsr == 10110, with period = 31.
REQ-038 en toggled 1,0,0,1 for 4 cycles: lfsr SHALL advance exactly 2 steps, and step_cnt SHALL equal 2.
REQ-039 reset=1 in the same cycle as load=1 and en=1: lfsr SHALL equal SEED and period SHALL equal 0 next cycle; load SHALL be ignored.
